gift_inv_round_key_perm_stage: RTL and testbench
================================================

# gift_inv_round_key_perm_stage

Registered GIFT-128 decryption stage that undoes AddRoundKey/AddRoundConstant and applies the inverse bit permutation (InvPermBits). It sits directly upstream of the 32-S-box inverse SubCells layer: its `outData` feeds that layer's 128-bit input unchanged. It carries a valid/ready handshake and a sideband tag, so a chain of stages forms a full-throughput decryption pipeline.

## Interface
- `TAG_WIDTH`, default 4: width of the sideband tag (round index / context id), passed through unmodified.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inValid` input 1: upstream presents a token.
- `inReady` output 1: stage accepts the token this cycle.
- `inData` input 128: cipher state; bit 0 = LSB, nibble i = bits [4i+3:4i].
- `roundKey` input 64: [63:32] = U, [31:0] = V; sampled with the token.
- `roundConst` input 6: c5..c0 as [5:0]; sampled with the token.
- `inTag` input TAG_WIDTH: sideband, sampled with the token.
- `outValid` output 1: registered token available.
- `outReady` input 1: downstream accepts.
- `outData` output 128: registered result.
- `outTag` output TAG_WIDTH: registered tag.

## Operation
- Transfer in: `inValid && inReady`. Transfer out: `outValid && outReady`.
- Mask step, combinational on accepted inputs, x = inData with:
  - for i in 0..31: x[4i+2] ^= U[i] and x[4i+1] ^= V[i];
  - x[3] ^= c0, x[7] ^= c1, x[11] ^= c2, x[15] ^= c3, x[19] ^= c4, x[23] ^= c5;
  - x[127] ^= 1, always.
- InvPermBits: outData[i] = x[P(i)] for i in 0..127, where P(i) = 4*floor(i/16) + 32*((3*floor((i mod 16)/4) + (i mod 4)) mod 4) + (i mod 4). This is the GIFT-128 forward permutation, which maps bit i to bit P(i).
- Single output register (data, tag, valid). No skid storage.
- `inReady = !outValid || outReady`. This is combinational, so it allows one transfer per cycle at full throughput.
- Register update:
  - on input transfer: load data, tag and outValid=1;
  - else on output transfer: outValid=0 and data/tag hold;
  - else: hold.
- Simultaneous in and out transfer: the new token replaces the old one and outValid stays 1.
- While `outValid && !outReady`: outData and outTag stay stable, and inReady=0.
- roundKey, roundConst and inTag are don't-care when inValid=0.
- No key schedule in this block. The upstream controller supplies the round key and constant for the round being undone.

## Timing
- Latency: 1 cycle. A token accepted at edge N appears with outValid=1 after edge N.
- Throughput: 1 token/cycle when outReady is held at 1.
- Reset values: outValid=0, outData=128'h0, outTag=0. inReady=1 during and after reset, since outValid=0.
- Reset mid-operation: a held token is discarded, and an input presented in the reset cycle is not captured. The first accept is possible in the cycle after rst deasserts.
- No combinational path from inData to outData. The only combinational path to an output is outReady -> inReady.

## Test plan
- Reset-then-zero: rst high for 2 cycles, then check outValid=0 and inReady=1. Send inData=0, U=V=0, rc=0, inTag=3. Next cycle: outData=128'h0008_0000_0000_0000_0000_0000_0000_0000, outTag=3.
- Permutation identity point: inData=128'h1, key=0, rc=0 -> outData=128'h0008_0000_0000_0000_0000_0000_0000_0001.
- Key mapping: inData=0, V=32'h1, U=0, rc=0 -> outData=128'h0008_…_0020 (bits 115 and 5). With U=32'h1, V=0 -> bits 115 and 10 (P(10)=2), i.e. 128'h0008_…_0400.
- Constant mapping: rc=6'h01, rest zero -> bits 115 and 15, i.e. 128'h0008_…_8000.
- Backpressure: stream 4 tokens with tags 0..3 and hold outReady=0 for 3 cycles after the first. Require:
  - inReady=0 while stalled;
  - outData/outTag stable;
  - no token lost or duplicated;
  - release gives in-order tags 0,1,2,3 with back-to-back acceptance.
- Reset mid-stream: with outValid=1 and outReady=0, assert rst for 1 cycle while inValid=1. Require outValid=0 the next cycle and no stale token delivered afterwards.
- Random: 10k random inData/key/rc with random valid/ready, compared against a reference model of mask followed by P-based permutation.

Source files
------------

// File: rtl/gift_inv_round_key_perm_stage.sv
// GIFT-128 decryption stage: removes round key and constant, then applies InvPermBits.
// One output register with a valid/ready handshake and a sideband tag carried alongside.
module gift_inv_round_key_perm_stage #(
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [127:0]         inData,
    input  logic [63:0]          roundKey,
    input  logic [5:0]           roundConst,
    input  logic [TAG_WIDTH-1:0] inTag,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [127:0]         outData,
    output logic [TAG_WIDTH-1:0] outTag
);

    logic [127:0]         masked;
    logic [127:0]         permuted;
    logic [127:0]         data_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 valid_q;
    logic                 in_xfer;
    logic                 out_xfer;

    // Source index for output bit i; this is the forward GIFT-128 bit map.
    function automatic int unsigned perm_src(input int unsigned i);
        int unsigned grp;
        int unsigned pos;
        grp = (i % 16) / 4;
        pos = i % 4;
        return 4 * (i / 16) + 32 * ((3 * grp + pos) % 4) + pos;
    endfunction

    always_comb begin
        masked = inData;
        for (int unsigned i = 0; i < 32; i++) begin
            masked[4*i+2] = masked[4*i+2] ^ roundKey[32+i];
            masked[4*i+1] = masked[4*i+1] ^ roundKey[i];
        end
        for (int unsigned j = 0; j < 6; j++) begin
            masked[4*j+3] = masked[4*j+3] ^ roundConst[j];
        end
        masked[127] = ~masked[127];
    end

    always_comb begin
        permuted = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            permuted[i] = masked[perm_src(i)];
        end
    end

    assign inReady  = !valid_q || outReady;
    assign in_xfer  = inValid && inReady;
    assign out_xfer = valid_q && outReady;

    // A simultaneous in/out transfer takes the load branch, so valid stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (in_xfer) begin
            valid_q <= 1'b1;
            data_q  <= permuted;
            tag_q   <= inTag;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign outValid = valid_q;
    assign outData  = data_q;
    assign outTag   = tag_q;

endmodule

// File: tb/tb_gift_inv_round_key_perm_stage.sv
// Self-checking bench: directed vectors plus randomized traffic against a token-queue
// reference model that applies the mask and permutation bit by bit.
module tb_gift_inv_round_key_perm_stage;

    localparam int unsigned TW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           inValid;
    logic           inReady;
    logic [127:0]   inData;
    logic [63:0]    roundKey;
    logic [5:0]     roundConst;
    logic [TW-1:0]  inTag;
    logic           outValid;
    logic           outReady;
    logic [127:0]   outData;
    logic [TW-1:0]  outTag;

    typedef struct packed {
        logic [127:0]  data;
        logic [TW-1:0] tag;
    } token_t;

    token_t        sb[$];
    logic [TW-1:0] delivered[$];
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic          rdy_seen;

    always #5 clk = ~clk;

    gift_inv_round_key_perm_stage #(.TAG_WIDTH(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .roundKey   (roundKey),
        .roundConst (roundConst),
        .inTag      (inTag),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .outTag     (outTag)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int unsigned perm_p(input int unsigned i);
        int unsigned q;
        int unsigned r;
        q = (i % 16) / 4;
        r = i % 4;
        return 4 * (i / 16) + 32 * ((3 * q + r) % 4) + r;
    endfunction

    // Mask nibble by nibble, then gather each output bit from its source position.
    function automatic logic [127:0] ref_model(input logic [127:0] d, input logic [63:0] k,
                                               input logic [5:0] c);
        logic [127:0] x;
        logic [127:0] y;
        logic [3:0]   flip;
        x = d;
        for (int n = 0; n < 32; n++) begin
            flip = {(n < 6) ? c[n] : 1'b0, k[32+n], k[n], 1'b0};
            x[4*n +: 4] = x[4*n +: 4] ^ flip;
        end
        x[127] = ~x[127];
        y = '0;
        for (int i = 0; i < 128; i++) y[i] = x[perm_p(i)];
        return y;
    endfunction

    task automatic cycle(input logic v, input logic [127:0] d, input logic [63:0] k,
                         input logic [5:0] c, input logic [TW-1:0] t,
                         input logic ordy, input logic r, output logic rdy);
        logic exp_ready;
        logic in_x;
        logic out_x;
        token_t tok;
        @(negedge clk);
        rst        = r;
        inValid    = v;
        inData     = d;
        roundKey   = k;
        roundConst = c;
        inTag      = t;
        outReady   = ordy;
        #1;
        rdy = inReady;
        exp_ready = (sb.size() == 0) || ordy;
        out_x = (sb.size() != 0) && ordy;
        in_x  = v && exp_ready;
        if (!r) begin
            check("in_ready", 128'(inReady), 128'(exp_ready));
            if (out_x) begin
                check("out_data_xfer", outData, sb[0].data);
                check("out_tag_xfer", 128'(outTag), 128'(sb[0].tag));
                delivered.push_back(outTag);
                void'(sb.pop_front());
            end
            if (in_x) begin
                tok.data = ref_model(d, k, c);
                tok.tag  = t;
                sb.push_back(tok);
            end
        end else begin
            sb.delete();
        end
        @(posedge clk);
        #1;
        check("out_valid", 128'(outValid), 128'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("out_data", outData, sb[0].data);
            check("out_tag", 128'(outTag), 128'(sb[0].tag));
        end
    endtask

    initial begin
        logic [127:0] bp_data[4];
        logic [127:0] rd;
        logic [63:0]  rk;

        cycle(1'b1, '0, '0, '0, '0, 1'b1, 1'b1, rdy_seen);
        cycle(1'b1, '1, '0, '0, '0, 1'b1, 1'b1, rdy_seen);
        check("rst_valid", 128'(outValid), 128'(0));
        check("rst_ready", 128'(inReady), 128'(1));
        check("rst_data", outData, 128'h0);
        check("rst_tag", 128'(outTag), 128'(0));

        cycle(1'b1, '0, '0, '0, 4'd3, 1'b1, 1'b0, rdy_seen);
        check("zero_vec", outData, 128'h0008_0000_0000_0000_0000_0000_0000_0000);
        check("zero_tag", 128'(outTag), 128'(3));
        cycle(1'b1, 128'h1, '0, '0, 4'd4, 1'b1, 1'b0, rdy_seen);
        check("ident_vec", outData, 128'h0008_0000_0000_0000_0000_0000_0000_0001);
        cycle(1'b1, '0, {32'h0, 32'h1}, '0, 4'd5, 1'b1, 1'b0, rdy_seen);
        check("v_key_vec", outData, 128'h0008_0000_0000_0000_0000_0000_0000_0020);
        cycle(1'b1, '0, {32'h1, 32'h0}, '0, 4'd6, 1'b1, 1'b0, rdy_seen);
        check("u_key_vec", outData, 128'h0008_0000_0000_0000_0000_0000_0000_0400);
        cycle(1'b1, '0, '0, 6'h01, 4'd7, 1'b1, 1'b0, rdy_seen);
        check("rc_vec", outData, 128'h0008_0000_0000_0000_0000_0000_0000_8000);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, rdy_seen);

        // Backpressure: stall three cycles after the first token, then stream.
        for (int i = 0; i < 4; i++) bp_data[i] = {$urandom, $urandom, $urandom, $urandom};
        delivered.delete();
        cycle(1'b1, bp_data[0], '0, '0, 4'd0, 1'b0, 1'b0, rdy_seen);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b1, bp_data[1], '0, '0, 4'd1, 1'b0, 1'b0, rdy_seen);
            check("stall_ready", 128'(rdy_seen), 128'(0));
            check("stall_data", outData, ref_model(bp_data[0], '0, '0));
            check("stall_tag", 128'(outTag), 128'(0));
        end
        for (int t = 1; t < 4; t++) begin
            cycle(1'b1, bp_data[t], '0, '0, 4'(t), 1'b1, 1'b0, rdy_seen);
            check("b2b_ready", 128'(rdy_seen), 128'(1));
        end
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, rdy_seen);
        check("bp_count", 128'(delivered.size()), 128'(4));
        for (int t = 0; t < 4 && t < delivered.size(); t++) begin
            check("bp_order", 128'(delivered[t]), 128'(t));
        end

        // Reset while a token is held and another is offered.
        cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, '0, 4'd9, 1'b0, 1'b0, rdy_seen);
        cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, '0, 4'd10, 1'b0, 1'b1, rdy_seen);
        check("rst_mid_valid", 128'(outValid), 128'(0));
        delivered.delete();
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, rdy_seen);
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, rdy_seen);
        check("rst_mid_stale", 128'(delivered.size()), 128'(0));

        for (int n = 0; n < 10000; n++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, rd, rk, 6'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, 1'b0, rdy_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
